// File: rtl/barrel_shift_pkg.sv
// -----------------------------------------------------------------------------
// barrel_shift_pkg
// Shared constants and types for the 16-bit barrel shifter slice.
//   DATA_W  : data word width (16)
//   SHIFT_W : shift amount width (4), covers amounts 0..15
//   data_t  : one data word
//   shamt_t : one shift amount
// -----------------------------------------------------------------------------
package barrel_shift_pkg;

  localparam int DATA_W  = 16;
  localparam int SHIFT_W = 4;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SHIFT_W-1:0] shamt_t;

endpackage : barrel_shift_pkg

// File: rtl/barrel_shift_stage.sv
// -----------------------------------------------------------------------------
// barrel_shift_stage
// One level of the log2 shift cascade: conditionally moves the word right by
// a fixed distance DIST.
//
// Configuration macro: BARREL_SHIFT_ROTATE_EN
//   defined   : bits leaving bit 0 wrap into the top DIST positions (rotate)
//   undefined : the top DIST positions fill with zeros (logical shift)
//
// Parameters:
//   DIST    : shift distance of this stage (1..DATA_W-1)
// Ports:
//   data    : input  word from the previous stage (or the block input)
//   enable  : input  when high, apply the DIST move; when low, pass through
//   shifted : output word for the next stage
// -----------------------------------------------------------------------------
import barrel_shift_pkg::*;

module barrel_shift_stage #(
  parameter int DIST = 1
) (
  input  data_t data,
  input  logic  enable,
  output data_t shifted
);

  data_t moved_s;

  // Fixed-distance move; the fill source is the only difference between builds.
`ifdef BARREL_SHIFT_ROTATE_EN
  assign moved_s = {data[DIST-1:0], data[DATA_W-1:DIST]};
`else
  assign moved_s = {{DIST{1'b0}}, data[DATA_W-1:DIST]};
`endif

  // Select between the moved word and a straight passthrough.
  always_comb begin
    shifted = data;
    if (enable) begin
      shifted = moved_s;
    end else begin
      shifted = data;
    end
  end

endmodule : barrel_shift_stage

// File: rtl/barrel_shift_16bit.sv
// -----------------------------------------------------------------------------
// barrel_shift_16bit
// Registered 16-bit right barrel shifter. Four cascaded stages (distances
// 1, 2, 4, 8, each enabled by one ctrl bit, LSB stage first) form the
// combinational result, which is captured into an output flop bank every
// rising clock edge. Latency is one cycle, throughput one word per cycle.
//
// Configuration macro: BARREL_SHIFT_ROTATE_EN
//   defined   : rotate right (wrapped bits re-enter at bit 15)
//   undefined : logical shift right with zero fill (default)
//
// Ports:
//   clk   : input  rising-edge clock
//   rst_n : input  asynchronous active-low reset, clears out to 16'h0000
//   in    : input  16-bit data word to shift
//   ctrl  : input  4-bit unsigned shift amount, 0..15
//   out   : output 16-bit registered shifted result
// -----------------------------------------------------------------------------
import barrel_shift_pkg::*;

module barrel_shift_16bit (
  input  logic  clk,
  input  logic  rst_n,
  input  data_t in,
  input  shamt_t ctrl,
  output data_t out
);

  // stage_s[0] is the raw input, stage_s[SHIFT_W] is the fully shifted word.
  data_t stage_s [SHIFT_W+1];

  assign stage_s[0] = in;

  // Stage i moves by 2**i when ctrl[i] is set; each feeds the next.
  for (genvar i = 0; i < SHIFT_W; i++) begin : g_stage
    barrel_shift_stage #(
      .DIST (1 << i)
    ) u_stage (
      .data    (stage_s[i]),
      .enable  (ctrl[i]),
      .shifted (stage_s[i+1])
    );
  end

  // Output register; reset clears it immediately and drops any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 16'h0000;
    end else begin
      out <= stage_s[SHIFT_W];
    end
  end

endmodule : barrel_shift_16bit

// File: tb/tb_barrel_shift_16bit.sv
// -----------------------------------------------------------------------------
// tb_barrel_shift_16bit
// Directed self-checking bench for barrel_shift_16bit. Inputs change and
// outputs are sampled on the falling clock edge, away from the capture edge.
// Expected values are hand-computed; build-dependent ones switch on
// BARREL_SHIFT_ROTATE_EN.
// -----------------------------------------------------------------------------
module tb_barrel_shift_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_v;
  logic [3:0]  ctrl_v;
  logic [15:0] out_v;

  int total_cnt;
  int bad_cnt;

  barrel_shift_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_v),
    .ctrl  (ctrl_v),
    .out   (out_v)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: count it, report a mismatch.
  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one operation at a falling edge, check it one full cycle later.
  task automatic apply_check(input string tag, input logic [15:0] d,
                             input logic [3:0] s, input logic [15:0] exp);
    in_v   = d;
    ctrl_v = s;
    @(negedge clk);
    check_eq(tag, out_v, exp);
  endtask

  // Expected 16'h8000 >> n for n = 0..15 (single bit, so both builds agree).
  logic [15:0] walk_exp [16];

  initial begin
    walk_exp[0]  = 16'h8000; walk_exp[1]  = 16'h4000;
    walk_exp[2]  = 16'h2000; walk_exp[3]  = 16'h1000;
    walk_exp[4]  = 16'h0800; walk_exp[5]  = 16'h0400;
    walk_exp[6]  = 16'h0200; walk_exp[7]  = 16'h0100;
    walk_exp[8]  = 16'h0080; walk_exp[9]  = 16'h0040;
    walk_exp[10] = 16'h0020; walk_exp[11] = 16'h0010;
    walk_exp[12] = 16'h0008; walk_exp[13] = 16'h0004;
    walk_exp[14] = 16'h0002; walk_exp[15] = 16'h0001;
  end

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n     = 1'b0;
    in_v      = 16'hFFFF;
    ctrl_v    = 4'd0;

    // Reset held across several rising edges: out stays zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("reset_hold", out_v, 16'h0000);
    end

    // Release between edges; still zero until the next rising edge.
    rst_n = 1'b1;
    #1;
    check_eq("reset_release_pre_edge", out_v, 16'h0000);
    @(negedge clk);
    check_eq("reset_release_load", out_v, 16'hFFFF);

    // Walking shift amount, one per cycle.
    for (int n = 0; n < 16; n++) begin
      apply_check($sformatf("walk_%0d", n), 16'h8000, n[3:0], walk_exp[n]);
    end

    // Multi-bit data and wrap boundary.
`ifdef BARREL_SHIFT_ROTATE_EN
    apply_check("multibit_00FF_4", 16'h00FF, 4'd4,  16'hF00F);
    apply_check("wrap_0001_1",     16'h0001, 4'd1,  16'h8000);
    apply_check("F0F0_8",          16'hF0F0, 4'd8,  16'hF0F0);
    apply_check("ABCD_4",          16'hABCD, 4'd4,  16'hDABC);
    apply_check("8001_15",         16'h8001, 4'd15, 16'h0003);
    apply_check("FFFF_15",         16'hFFFF, 4'd15, 16'hFFFF);
`else
    apply_check("multibit_00FF_4", 16'h00FF, 4'd4,  16'h000F);
    apply_check("wrap_0001_1",     16'h0001, 4'd1,  16'h0000);
    apply_check("F0F0_8",          16'hF0F0, 4'd8,  16'h00F0);
    apply_check("ABCD_4",          16'hABCD, 4'd4,  16'h0ABC);
    apply_check("8001_15",         16'h8001, 4'd15, 16'h0001);
    apply_check("FFFF_15",         16'hFFFF, 4'd15, 16'h0001);
`endif
    apply_check("C3A5_0",          16'hC3A5, 4'd0,  16'hC3A5);

    // Passthrough and one-cycle latency.
    apply_check("pass_A5A5", 16'hA5A5, 4'd0, 16'hA5A5);
    apply_check("pass_next", 16'h0000, 4'd0, 16'h0000);

    // Input changes between edges must not reach out early.
    in_v = 16'h1234;
    #2;
    check_eq("no_early_change", out_v, 16'h0000);
    @(negedge clk);
    check_eq("load_1234", out_v, 16'h1234);

    // Async reset mid-stream: clears before the next rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_clear", out_v, 16'h0000);
    @(negedge clk);
    check_eq("async_reset_hold", out_v, 16'h0000);
    rst_n = 1'b1;
    #1;
    check_eq("async_release_pre_edge", out_v, 16'h0000);
    @(negedge clk);
    check_eq("async_release_reload", out_v, 16'h1234);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule : tb_barrel_shift_16bit
